// File: rtl/ahb_top.sv
// AHB-Lite subsystem: command-driven master, ss decoder, read mux, GPIO/RAM/default slaves.
// Latency: a command sampled at edge N completes (write lands / dout loads) at edge N+1.
// Backpressure: none; every slave is zero-wait, so HREADY stays high and a command issues every cycle en=1.
module ahb_top #(
  parameter int MEM_WORDS = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] gpioW,
  input  logic [31:0] cAddr,
  input  logic        en,
  input  logic        cWr,
  input  logic [1:0]  ss,
  output logic [31:0] dout,
  output logic [7:0]  LED
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic       HRESP_OKAY    = 1'b0;

  // Address-phase bus, driven combinationally by the master and decoder
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [3:0]  hsel;

  // Data-phase bus
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  // Data-phase state captured at the end of the address phase
  logic             dp_vld;
  logic             dp_write;
  logic [3:0]       dp_sel;
  logic [IDX_W-1:0] dp_idx;

  // Slave storage
  logic [31:0] gpio_reg;
  logic [31:0] mem [MEM_WORDS];

  // Address bits outside the RAM word index and the fixed transfer size carry no information here
  logic unused_bits;
  assign unused_bits = ^{haddr[31:IDX_W+2], haddr[1:0], hsize, dp_sel[3:2]};

  assign hready = 1'b1;
  assign hresp  = HRESP_OKAY;
  assign haddr  = cAddr;
  assign hwrite = cWr;
  assign hsize  = HSIZE_WORD;
  assign htrans = en ? HTRANS_NONSEQ : HTRANS_IDLE;

  // Decoder: one-hot select from ss, nothing selected on an idle cycle
  always_comb begin
    hsel = 4'b0000;
    if (en) hsel[ss] = 1'b1;
  end

  // Master and slave pipeline registers; reset drops any data phase in flight
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      dp_vld   <= 1'b0;
      dp_write <= 1'b0;
      dp_sel   <= 4'b0000;
      dp_idx   <= '0;
      hwdata   <= 32'h0;
    end else if (hready) begin
      dp_vld   <= (htrans == HTRANS_NONSEQ);
      dp_write <= hwrite;
      dp_sel   <= hsel;
      dp_idx   <= haddr[IDX_W+1:2];
      if (htrans == HTRANS_NONSEQ) hwdata <= gpioW;
    end
  end

  // Read-data mux: GPIO, RAM, else the default slave's zero
  always_comb begin
    hrdata = 32'h0;
    if (dp_sel[0])      hrdata = gpio_reg;
    else if (dp_sel[1]) hrdata = mem[dp_idx];
  end

  // GPIO slave register, written at the end of its data phase
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      gpio_reg <= 32'h0;
    end else if (hready && dp_vld && dp_write && dp_sel[0]) begin
      gpio_reg <= hwdata;
    end
  end

  assign LED = gpio_reg[7:0];

  // RAM slave write port; contents deliberately survive reset
  always_ff @(posedge Clk) begin
    if (hready && dp_vld && dp_write && dp_sel[1]) begin
      mem[dp_idx] <= hwdata;
    end
  end

  // Master read capture: dout loads only on a completed read and holds otherwise
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      dout <= 32'h0;
    end else if (hready && dp_vld && !dp_write && hresp == HRESP_OKAY) begin
      dout <= hrdata;
    end
  end

endmodule

// File: tb/tb_ahb_top.sv
// Directed bench for ahb_top: GPIO, RAM, default slave, pipelining and mid-transfer reset.
// Inputs change 1ns after a rising edge; outputs are checked at that same point.
// Each command is sampled at the next edge and its result is visible after the edge following that.
module tb_ahb_top;

  logic        Clk;
  logic        Rst;
  logic [31:0] gpioW;
  logic [31:0] cAddr;
  logic        en;
  logic        cWr;
  logic [1:0]  ss;
  logic [31:0] dout;
  logic [7:0]  LED;

  int n_tests;
  int n_fail;

  ahb_top #(.MEM_WORDS(16)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .gpioW (gpioW),
    .cAddr (cAddr),
    .en    (en),
    .cWr   (cWr),
    .ss    (ss),
    .dout  (dout),
    .LED   (LED)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Single comparison point for every check in the bench
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one command, then step past the edge that samples it
  task automatic cmd(input logic e, input logic wr, input logic [1:0] s,
                     input logic [31:0] a, input logic [31:0] d);
    en    = e;
    cWr   = wr;
    ss    = s;
    cAddr = a;
    gpioW = d;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    cmd(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    Rst   = 1'b0;
    en    = 1'b0;
    cWr   = 1'b0;
    ss    = 2'd0;
    cAddr = 32'h0;
    gpioW = 32'h0;

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_led",  {24'h0, LED}, 32'h0);
    chk("rst_dout", dout,         32'h0);
    Rst = 1'b1;
    idle();
    idle();
    chk("idle_led", {24'h0, LED}, 32'h0);

    // GPIO read after reset
    cmd(1'b1, 1'b0, 2'd0, 32'h0, 32'h0);
    idle();
    chk("gpio_rd0", dout, 32'h0);

    // GPIO write then read back-to-back
    cmd(1'b1, 1'b1, 2'd0, 32'h0, 32'h0000_000A);
    chk("gpio_wr_lat", {24'h0, LED}, 32'h0);
    cmd(1'b1, 1'b0, 2'd0, 32'h0, 32'h0);
    chk("gpio_wr_led", {24'h0, LED}, 32'h0A);
    idle();
    chk("gpio_rd_a", dout, 32'h0000_000A);

    // RAM: two writes then two reads, fully pipelined, then a wrapped address
    cmd(1'b1, 1'b1, 2'd1, 32'h4,  32'hDEAD_BEEF);
    cmd(1'b1, 1'b1, 2'd1, 32'h8,  32'h1234_5678);
    cmd(1'b1, 1'b0, 2'd1, 32'h4,  32'h0);
    cmd(1'b1, 1'b0, 2'd1, 32'h8,  32'h0);
    chk("ram_rd4", dout, 32'hDEAD_BEEF);
    cmd(1'b1, 1'b0, 2'd1, 32'h44, 32'h0);
    chk("ram_rd8", dout, 32'h1234_5678);
    idle();
    chk("ram_wrap", dout, 32'hDEAD_BEEF);
    chk("ram_led",  {24'h0, LED}, 32'h0A);

    // Read-after-write to the same RAM word on consecutive cycles, then dout holds
    cmd(1'b1, 1'b1, 2'd1, 32'hC, 32'hCAFE_F00D);
    cmd(1'b1, 1'b0, 2'd1, 32'hC, 32'h0);
    idle();
    chk("ram_raw", dout, 32'hCAFE_F00D);
    idle();
    chk("dout_hold", dout, 32'hCAFE_F00D);

    // Default slave: write ignored, read returns zero
    cmd(1'b1, 1'b1, 2'd2, 32'h0, 32'hFFFF_FFFF);
    cmd(1'b1, 1'b0, 2'd2, 32'h0, 32'h0);
    idle();
    chk("dflt_rd",  dout, 32'h0);
    chk("dflt_led", {24'h0, LED}, 32'h0A);
    cmd(1'b1, 1'b0, 2'd3, 32'h0, 32'h0);
    cmd(1'b1, 1'b0, 2'd1, 32'hC, 32'h0);
    chk("dflt3_rd", dout, 32'h0);
    idle();
    chk("ram_after_dflt", dout, 32'hCAFE_F00D);

    // GPIO stores all 32 bits and ignores the address
    cmd(1'b1, 1'b1, 2'd0, 32'h100, 32'hA5A5_0033);
    cmd(1'b1, 1'b0, 2'd0, 32'h7C,  32'h0);
    idle();
    chk("gpio_full", dout, 32'hA5A5_0033);
    chk("gpio_led33", {24'h0, LED}, 32'h33);

    // Reset between the address phase and the data-phase edge of a GPIO write
    cmd(1'b1, 1'b1, 2'd0, 32'h0, 32'h0000_0055);
    Rst = 1'b0;
    en  = 1'b0;
    #1;
    chk("midrst_led",  {24'h0, LED}, 32'h0);
    chk("midrst_dout", dout,         32'h0);
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    idle();
    chk("postrst_led", {24'h0, LED}, 32'h0);
    cmd(1'b1, 1'b0, 2'd0, 32'h0, 32'h0);
    idle();
    chk("postrst_gpio", dout, 32'h0);
    cmd(1'b1, 1'b0, 2'd1, 32'h4, 32'h0);
    idle();
    chk("ram_kept", dout, 32'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_top.md
Name: ahb_top

Overview:
- Self-contained AHB-Lite subsystem: one simple master driven by a user command interface, a slave-select decoder, a read-data mux and three slave types (GPIO, RAM, default).
- Lets a testbench or top level read and write a GPIO register, whose low byte drives LEDs, and a small RAM, through a real two-phase (address/data) AHB-Lite pipeline.

Parameters:
- MEM_WORDS, 16, depth of the slave-1 RAM in 32-bit words (power of two).

Ports:
- Clk  input  1  system clock, rising edge
- Rst  input  1  asynchronous, active-low reset
- gpioW  input  32  write data for the current command
- cAddr  input  32  byte address for the current command
- en  input  1  command valid; a transfer is issued on every clock edge where en=1
- cWr  input  1  1=write, 0=read
- ss  input  2  slave select: 0=GPIO, 1=RAM, 2/3=default slave
- dout  output  32  last completed read data (registered)
- LED  output  8  GPIO register bits [7:0]

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - LED=0, dout=0, GPIO register=0.
  - Master returns to idle with no data phase pending.
  - RAM contents are not reset.
- Internal bus:
  - Signals: HADDR, HWRITE, HTRANS, HSIZE=word, HSEL[3:0] one-hot from ss, HWDATA, HRDATA, HREADY.
  - All slaves are zero-wait, so HREADY=1 always and HRESP=OKAY always.
- Address phase, in the cycle where en=1:
  - Master drives HTRANS=NONSEQ, HADDR=cAddr, HWRITE=cWr, HSEL=decode(ss).
  - When en=0: HTRANS=IDLE and no slave is selected.
- Pipeline capture: at the rising edge ending the address phase, the master registers gpioW, and the slaves register the address, write flag and select.
- Data phase, the following cycle:
  - Master drives the registered write data on HWDATA.
  - Selected slave drives HRDATA.
  - The transfer completes at the end of this cycle.
- Latency:
  - A write sampled at edge N updates its target at edge N+1.
  - A read sampled at edge N loads dout from HRDATA at edge N+1.
  - dout holds its value when there is no read completion.
- Back-to-back transfers: en held high issues a new transfer every cycle, fully pipelined. The address phase of transfer k+1 overlaps the data phase of transfer k.
- Command mix: commands may alternate between read/write or change slave every cycle.
- Read-after-write to the same location on consecutive cycles returns the newly written value (the write takes effect at the same edge that ends the read's address phase, so the read's data phase sees the new value).
- en dropping: a data phase already in flight still completes normally.
- GPIO slave (ss=0):
  - Single 32-bit register; address bits are ignored.
  - Write stores all 32 bits of HWDATA; read returns the full register.
  - LED = register[7:0] continuously.
- RAM slave (ss=1):
  - MEM_WORDS x 32, word index = HADDR[log2(MEM_WORDS)+1:2]; upper bits are ignored, so addresses wrap.
  - Synchronous write at data-phase end; combinational read during the data phase.
- Default slave (ss=2,3): reads return 0, writes are ignored, response OKAY.
- Reset asserted mid-transfer: the pending data phase is aborted with no write, and outputs go to reset values immediately.
- No interaction between slaves: a write to the RAM or default slave never changes LED.

Test Plan:
- Reset: hold Rst=0 then release, en=0 -> LED=0x00, dout=0x00000000, no transfers.
- GPIO read: ss=0, en=1, cWr=0 after reset -> dout=0x00000000 one edge after the command is sampled.
- GPIO write: ss=0, en=1, cWr=1, gpioW=0x0000000A -> LED=0x0A one edge after sampling; then switch to read (cWr=0) -> dout=0x0000000A.
- RAM: ss=1, write 0xDEADBEEF to cAddr=0x4, then 0x12345678 to 0x8 back-to-back, then read 0x4 and 0x8 back-to-back -> dout=0xDEADBEEF then 0x12345678 on consecutive edges; LED unchanged. Read 0x44 (wrap with MEM_WORDS=16) -> 0xDEADBEEF.
- Default slave: ss=2, write 0xFFFFFFFF then read -> dout=0x00000000, LED unchanged.
- Reset mid-operation: GPIO write of 0x55 issued, Rst asserted before the data-phase edge -> LED=0x00, dout=0; after release, GPIO read returns 0.
